pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Decodes a PWM waveform: measures high time and period of pwm_in and reports duty as a DUTY_W-bit fraction of full scale.
//  Receive-side counterpart of the on-board PWM generators (8-bit, 256-cycle LED throbber style).
//  Used for self-test loopback of generator outputs and for reading external PWM sources into the core.
// PARAMETERS
//  CNT_W       16     width of high/period counters and count outputs
//  DUTY_W      8      duty result width; duty = floor(high*2^DUTY_W/period)
//  SYNC_STAGES 2      input synchroniser flops (>=2)
//  TIMEOUT     65535  cycles without rising edge before stall; must be <= 2^CNT_W-1
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       asynchronous, active-low reset
//  pwm_in        in   1       asynchronous PWM input
//  high_count    out  CNT_W   high-time cycles of last complete period
//  period_count  out  CNT_W   cycle count of last complete period
//  duty          out  DUTY_W  last duty result
//  valid         out  1       1-cycle strobe: duty/high_count/period_count updated
//  stalled       out  1       no rising edge within TIMEOUT cycles
//  overrun       out  1       1-cycle strobe: completed period dropped (divider busy)
// BEHAVIOUR
//  - Reset: all outputs 0; state ARM; counters 0; divider idle. All regs asynchronously reset.
//  - pwm_in passes SYNC_STAGES flops, then one level register s; rise = s & !s_d, fall = !s & s_d.
//  - States: ARM (wait first rise, no measurement) -> MEAS on rise. MEAS -> ARM on timeout.
//  - In MEAS: per_cnt +1 every cycle, hi_cnt +1 every cycle s=1. Rise cycle: per_cnt,hi_cnt reload to 1.
//  - On rise in MEAS (cycle E): high_count<=hi_cnt, period_count<=per_cnt, divider starts.
//  - Divider: serial restoring, one quotient bit/cycle; valid and duty update at E+DUTY_W+1.
//  - hi_cnt < per_cnt always (low phase >=1 cycle), so quotient fits DUTY_W bits; no clamp.
//  - Rise while divider busy: capture dropped, count outputs unchanged, overrun pulses at E; counters still reload.
//  - Timeout: per_cnt == TIMEOUT in MEAS or ARM -> stalled<=1, duty<= all-ones if s=1 else 0,
//    high_count/period_count<=0, valid pulses once, state ARM, counters clear; in-flight division aborted.
//  - stalled clears on next normal valid. No repeated timeout valid while still stalled.
//  - Counters never wrap: TIMEOUT bounds them.
//  - Timeout and rise in same cycle: rise wins (normal measurement).
//  - Reset mid-division: result discarded, no valid.
//  - Glitches shorter than a cycle may be missed; no debounce.
// STRUCTURE
//  - Shared package: state enum {ARM, MEAS}; localparam DIV_CYCLES = DUTY_W+1.
//  - Sub-module pwm_div: serial unsigned divider (numerator hi<<DUTY_W, denominator per,
//    start/busy/done handshake, quotient DUTY_W bits). Top holds sync, edge detect, counters, FSM.
// TESTING
//  1 Reset, pwm_in period 256 high 64, 4 periods -> first rise no valid; then valid: period_count=256, high_count=64, duty=64.
//  2 Period 256, high 255 -> duty=255; high 1 -> duty=1; period 3 high 1 -> duty=85.
//  3 Hold pwm_in high after last rise, TIMEOUT=1000 -> stalled=1, duty=255, one valid; resume -> stalled=0 after 2nd rise.
//  4 Period 5 (< DUTY_W+1 cycles), DUTY_W=8 -> alternate periods overrun pulse, outputs reflect accepted periods only.
//  5 Assert reset_n low mid-division -> outputs 0, no valid; resume -> ARM behaviour as scenario 1.
//  6 Loop back throbber output, sweep -> duty tracks 256-limit-ish ramp, monotonic within each half-cycle.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
// Holds the measurement FSM encoding and divider timing.
package pwm_capture_pkg;

    typedef enum logic [0:0] {
        ARM  = 1'b0,
        MEAS = 1'b1
    } state_e;

    localparam int DUTY_W_DEF = 8;
    localparam int DIV_CYCLES = DUTY_W_DEF + 1;

    function automatic int div_cycles(input int duty_w);
        return duty_w + 1;
    endfunction

endpackage

// File: rtl/pwm_capture_div.sv
// Serial restoring divider: quot = floor((num << DUTY_W) / den).
// Requires num < den so the quotient fits in DUTY_W bits.
module pwm_div
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quot
);

    localparam int CW = $clog2(DUTY_W + 1);

    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  den_q;
    logic [DUTY_W-1:0] q;
    logic [CW-1:0]     cnt;

    logic [CNT_W:0]    trial;
    logic              ge;
    logic [CNT_W-1:0]  rem_nxt;
    logic [DUTY_W-1:0] q_nxt;

    // num < den, so the upper quotient bits are zero and rem starts at num
    always_comb begin
        trial   = {rem, 1'b0};
        ge      = (trial >= {1'b0, den_q});
        rem_nxt = ge ? CNT_W'(trial - {1'b0, den_q})
                     : trial[CNT_W-1:0];
        q_nxt   = {q[DUTY_W-2:0], ge};
    end

    assign done = busy && (cnt == CW'(1));
    assign quot = q_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem   <= '0;
            den_q <= '0;
            q     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            rem   <= num;
            den_q <= den;
            q     <= '0;
            cnt   <= CW'(DUTY_W);
            busy  <= 1'b1;
        end else if (busy) begin
            rem <= rem_nxt;
            q   <= q_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures high time and period of pwm_in and
// reports duty as a DUTY_W-bit fraction of full scale.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DUTY_W      = DUTY_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  high_count,
    output logic [CNT_W-1:0]  period_count,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              stalled,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;

    state_e           state;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;

    logic             tmo_hit;
    logic             timeout_ev;
    logic             rise_meas;
    logic             accept;

    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s      <= sync_q[SYNC_STAGES-1];
            s_d    <= s;
        end
    end

    assign rise       = s & ~s_d;
    assign tmo_hit    = (per_cnt == TMO);
    assign timeout_ev = tmo_hit & ~rise;
    assign rise_meas  = rise & (state == MEAS);
    assign accept     = rise_meas & ~div_busy;
    assign overrun    = rise_meas & div_busy;

    // Counters reload to 1 on a rise so the rise cycle belongs to the new period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ARM;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            state   <= MEAS;
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else if (tmo_hit) begin
            state   <= ARM;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (state == MEAS) begin
            per_cnt <= per_cnt + CNT_W'(1);
            hi_cnt  <= hi_cnt + CNT_W'(s);
        end else begin
            per_cnt <= per_cnt + CNT_W'(1);
        end
    end

    pwm_div #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept),
        .abort   (timeout_ev),
        .num     (hi_cnt),
        .den     (per_cnt),
        .busy    (div_busy),
        .done    (div_done),
        .quot    (div_q)
    );

    // A stall reports once; later timeouts only re-arm the counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_count   <= '0;
            period_count <= '0;
            duty         <= '0;
            valid        <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (accept) begin
                high_count   <= hi_cnt;
                period_count <= per_cnt;
            end
            if (timeout_ev) begin
                if (!stalled) begin
                    stalled      <= 1'b1;
                    duty         <= s ? '1 : '0;
                    high_count   <= '0;
                    period_count <= '0;
                    valid        <= 1'b1;
                end
            end else if (div_done) begin
                duty    <= div_q;
                valid   <= 1'b1;
                stalled <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised bench for pwm_capture against an event-level model
// derived from rise times and high/period arithmetic.
module tb_pwm_capture;

    localparam int CNT_W  = 16;
    localparam int DUTY_W = 8;
    localparam int SYNC   = 2;
    localparam int TMO    = 1000;
    localparam int DIVC   = DUTY_W + 1;
    localparam int LAT    = SYNC + 1;
    localparam int MAXC   = 16384;
    localparam int FULL   = (1 << DUTY_W) - 1;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              pwm_in  = 1'b0;
    logic [CNT_W-1:0]  high_count;
    logic [CNT_W-1:0]  period_count;
    logic [DUTY_W-1:0] duty;
    logic              valid;
    logic              stalled;
    logic              overrun;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .DUTY_W      (DUTY_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .duty         (duty),
        .valid        (valid),
        .stalled      (stalled),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    bit w    [MAXC];
    int wl;
    bit ev_v [MAXC];
    bit ev_o [MAXC];
    bit ev_s [MAXC];
    int ev_d [MAXC];
    int ev_h [MAXC];
    int ev_p [MAXC];

    int checks = 0;
    int errors = 0;
    int cur_c  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     tag, cur_c, got, exp);
        end
    endtask

    function automatic void hold(input bit lv, input int n);
        for (int j = 0; j < n; j++) begin
            if (wl < MAXC) begin
                w[wl] = lv;
                wl++;
            end
        end
    endfunction

    function automatic void add(input int p, input int h);
        for (int j = 0; j < p; j++) begin
            if (wl < MAXC) begin
                w[wl] = (j < h);
                wl++;
            end
        end
    endfunction

    function automatic void add_rand(input int pmin, input int pmax);
        int p;
        p = int'($urandom_range(pmax, pmin));
        add(p, int'($urandom_range(p - 1, 1)));
    endfunction

    function automatic bit lvl(input int c);
        return (c >= LAT && c - LAT < wl) ? w[c-LAT] : 1'b0;
    endfunction

    function automatic void post(input int c, input int d, input int h,
                                 input int p, input bit st, input int lim);
        if (c < lim) begin
            ev_v[c] = 1'b1;
            ev_d[c] = d;
            ev_h[c] = h;
            ev_p[c] = p;
            ev_s[c] = st;
        end
    endfunction

    // Expected output events for one reset-to-reset window of length lim
    task automatic build_model(input int lim);
        int rises[$];
        int anchor;
        int prev;
        int last_acc;
        int r;
        int to;
        int e;
        int hi;
        bit meas;
        bit stl;
        anchor   = 0;
        prev     = 0;
        last_acc = -100000;
        r        = 0;
        meas     = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            ev_v[c] = 1'b0;
            ev_o[c] = 1'b0;
        end
        for (int i = 1; i < wl; i++) begin
            if (w[i] && !w[i-1]) rises.push_back(i + LAT);
        end
        while (1) begin
            to = anchor + TMO;
            if (r < rises.size() && rises[r] <= to) begin
                e = rises[r];
                r++;
                if (meas && e - last_acc >= DIVC) begin
                    hi = 0;
                    for (int j = prev; j < e; j++) hi += int'(lvl(j));
                    post(e + DIVC, (hi << DUTY_W) / (e - prev),
                         hi, e - prev, 1'b0, lim);
                    last_acc = e;
                end else if (meas && e < lim) begin
                    ev_o[e] = 1'b1;
                end
                meas   = 1'b1;
                anchor = e;
                prev   = e;
            end else begin
                if (to >= lim) break;
                for (int c = to + 1; c < lim && c <= to + DIVC; c++)
                    ev_v[c] = 1'b0;
                stl = 1'b0;
                for (int c = to; c >= 0; c--) begin
                    if (ev_v[c]) begin
                        stl = ev_s[c];
                        break;
                    end
                end
                if (!stl)
                    post(to + 1, lvl(to) ? FULL : 0, 0, 0, 1'b1, lim);
                meas     = 1'b0;
                anchor   = to + 1;
                last_acc = -100000;
            end
        end
    endtask

    task automatic run_phase(input int lim);
        build_model(lim);
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            cur_c = c;
            if (c == 0) begin
                check("rst_duty", duty, 0);
                check("rst_high", high_count, 0);
                check("rst_period", period_count, 0);
                check("rst_stalled", stalled, 0);
            end
            check("valid", valid, ev_v[c]);
            check("overrun", overrun, ev_o[c]);
            if (ev_v[c]) begin
                check("duty", duty, ev_d[c]);
                check("high_count", high_count, ev_h[c]);
                check("period_count", period_count, ev_p[c]);
                check("stalled", stalled, ev_s[c]);
            end
            reset_n = 1'b1;
            pwm_in  = (c < wl) ? w[c] : 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", valid, 0);
            check("rst_duty", duty, 0);
            check("rst_high", high_count, 0);
            check("rst_period", period_count, 0);
            check("rst_stalled", stalled, 0);
            check("rst_overrun", overrun, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int vc;
        int h;

        // fixed duties, dropped rises, stall high then stall low
        wl = 0;
        hold(0, 4);
        repeat (4) add(256, 64);
        add(256, 255);
        add(256, 1);
        add(6, 2);
        add(3, 1);
        add(20, 5);
        repeat (6) add_rand(10, 300);
        hold(1, 1200);
        hold(0, int'($urandom_range(20, 5)));
        repeat (5) add_rand(10, 300);
        hold(0, 1200);
        add(30, 10);
        run_phase(wl);
        do_reset();

        // periods shorter than the divider latency
        wl = 0;
        hold(0, 3);
        repeat (12) add(5, int'($urandom_range(4, 1)));
        repeat (10) add_rand(2, 12);
        add(40, 7);
        run_phase(wl);
        do_reset();

        // reset lands while a division is in flight
        wl = 0;
        hold(0, 3);
        repeat (4) add_rand(20, 200);
        build_model(wl);
        vc = -1;
        for (int c = 0; c < wl; c++) if (ev_v[c]) vc = c;
        if (vc < 0) begin
            check("setup_valid_found", 0, 1);
            vc = wl;
        end
        run_phase(vc - 4);
        do_reset();

        // throbber-style ramp up then down at period 256
        wl = 0;
        hold(0, 5);
        h = 1;
        while (h < 256) begin
            add(256, h);
            h += int'($urandom_range(40, 17));
        end
        h = 255;
        while (h > 0) begin
            add(256, h);
            h -= int'($urandom_range(40, 17));
        end
        add(256, 128);
        run_phase(wl);
        do_reset();

        // free random traffic with a low stall in the middle
        wl = 0;
        hold(0, 3);
        repeat (30) add_rand(2, 150);
        hold(0, 1100);
        repeat (20) add_rand(2, 150);
        add(50, 20);
        run_phase(wl);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
